mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory arbiter slice.
//   word_t      - 32-bit bus word, used for every address and data bus
//   ramstate_t  - RAM status reported back to the arbiter
//   arb_state_t - arbiter FSM states
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one RAM port between an icache (read only) and a
// dcache (read/write). One grant is served at a time; every completed access
// is followed by a mandatory idle cycle.
//
// Ports
//   CLK, RST            clock; asynchronous active-high reset
//   iREN, iaddr         icache read request and word address
//   iwait, iload        icache stall and read data
//   dREN, dWEN          dcache read / write requests
//   daddr, dstore       dcache address and write data
//   dwait, dload        dcache stall and read data
//   ramREN, ramWEN      RAM strobes
//   ramaddr, ramstore   RAM address and write data
//   ramload, ramstate   RAM read data and status {FREE, BUSY, ACCESS, ERROR}
//   arb_err             sticky fault flag (RAM ERROR or grant timeout)
//
// Parameter TIMEOUT (1..256): grant cycles allowed without ACCESS or ERROR.
//
// Build option MEM_ARBITER_RR_EN: when defined, simultaneous requests in IDLE
// are granted round-robin using a last_grant register; when undefined the
// dcache always wins and no last_grant register exists.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        arb_err
);

   localparam logic [7:0] BUSY_LAST = 8'(TIMEOUT - 1);

   arb_state_t state;
   logic [7:0] busy_cnt;
   logic       err_q;
   ramstate_t  rs;
   logic       ireq;
   logic       dreq;
   logic       granted_req;
   logic       done;
   logic       fault;
   logic       wait_rel;
   logic       pick_d;
   word_t      bus_ld;

   assign rs     = ramstate_t'(ramstate);
   assign ireq   = iREN;
   assign dreq   = dREN | dWEN;
   assign bus_ld = ramload;
   assign iload  = bus_ld;
   assign dload  = bus_ld;

`ifdef MEM_ARBITER_RR_EN
   // 1 = dcache held the most recently completed grant
   logic last_d;
   assign pick_d = dreq & (~ireq | ~last_d);
`else
   assign pick_d = dreq;
`endif

   always_comb begin
      granted_req = 1'b0;
      case (state)
         IGNT:    granted_req = ireq;
         DGNT:    granted_req = dreq;
         default: granted_req = 1'b0;
      endcase
   end

   // A dropped request ends the grant silently, so it masks both outcomes.
   assign done     = granted_req && (rs == ACCESS);
   assign fault    = granted_req && ((rs == ERROR) ||
                                     ((rs != ACCESS) && (busy_cnt == BUSY_LAST)));
   assign wait_rel = done | fault;

   // The fault term lets the flag show in the same cycle the fault is seen.
   assign arb_err  = err_q | fault;

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = ireq;
      dwait    = dreq;
      case (state)
         IGNT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            iwait   = ~wait_rel;
         end
         DGNT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dwait    = ~wait_rel;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         busy_cnt <= '0;
         err_q    <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
         last_d   <= 1'b0;
`endif
      end else begin
         if (fault) err_q <= 1'b1;
         case (state)
            IDLE: begin
               // Held at zero in IDLE so every grant starts from a cleared count.
               busy_cnt <= '0;
               if (pick_d)    state <= DGNT;
               else if (ireq) state <= IGNT;
            end
            default: begin
               if (!granted_req || wait_rel) state <= IDLE;
               else if (busy_cnt != '1)      busy_cnt <= busy_cnt + 8'd1;
`ifdef MEM_ARBITER_RR_EN
               if (done) last_d <= (state == DGNT);
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run scored against a
// cycle-level behavioural model of the arbiter.
module tb_mem_arbiter;

   localparam int unsigned TO = 64;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN, arb_err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   int vectors = 0;
   int miscompares = 0;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   // m_owner: 0 nobody, 1 icache, 2 dcache. m_cyc: 1-based grant cycle number.
   int   m_owner, m_cyc;
   bit   m_err, m_last_d;
   bit   m_greq, m_done, m_fault;
   logic e_iwait, e_dwait, e_ren, e_wen, e_err;
   logic [31:0] e_addr, e_store;

   task automatic model_reset();
      m_owner = 0; m_cyc = 0; m_err = 0; m_last_d = 0;
   endtask

   task automatic model_outputs();
      bit ir, dr;
      ir = iREN; dr = dREN | dWEN;
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
      e_iwait = ir; e_dwait = dr;
      m_greq = 0; m_done = 0; m_fault = 0;
      if (m_owner == 1) begin
         e_ren = 1; e_addr = iaddr; m_greq = ir;
      end else if (m_owner == 2) begin
         e_addr = daddr; e_store = dstore; e_wen = dWEN;
         e_ren = dREN & ~dWEN; m_greq = dr;
      end
      if (m_owner != 0 && m_greq) begin
         m_done  = (ramstate == 2'd2);
         m_fault = (ramstate == 2'd3) || (ramstate != 2'd2 && m_cyc == TO);
      end
      if (m_owner == 1) e_iwait = !(m_done || m_fault);
      if (m_owner == 2) e_dwait = !(m_done || m_fault);
      e_err = m_err || m_fault;
   endtask

   task automatic model_step();
      bit ir, dr;
      ir = iREN; dr = dREN | dWEN;
      if (m_owner == 0) begin
         if (ir && dr) begin
`ifdef MEM_ARBITER_RR_EN
            m_owner = m_last_d ? 1 : 2;
`else
            m_owner = 2;
`endif
         end else if (dr) m_owner = 2;
         else if (ir)     m_owner = 1;
         m_cyc = 1;
      end else if (!m_greq || m_done || m_fault) begin
         if (m_greq && m_done) m_last_d = (m_owner == 2);
         m_owner = 0;
      end else begin
         m_cyc++;
      end
      if (m_fault) m_err = 1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(posedge CLK); #1;
   endtask

   task automatic idle_inputs();
      iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST = 1;
      next_cycle(); next_cycle();
      RST = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      #3;
      vectors++;
      if ({ramREN, ramWEN, iwait, dwait, arb_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b want 00000", {ramREN, ramWEN, iwait, dwait, arb_err});
      end
      vectors++;
      if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_buses: got addr %h store %h want 0 0", ramaddr, ramstore);
      end
      next_cycle();
   endtask

   task automatic test_icache_read();
      do_reset();
      iREN = 1; iaddr = 32'h40;
      #3;
      vectors++;
      if (ramREN !== 1'b0 || iwait !== 1'b1) begin
         miscompares++;
         $display("FAIL iread_idle: got ren %b iwait %b want 0 1", ramREN, iwait);
      end
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         ramstate = (k == 3) ? 2'd2 : 2'd1;
         ramload  = (k == 3) ? 32'hDEADBEEF : 32'h0;
         #3;
         vectors++;
         if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== (k != 3)) begin
            miscompares++;
            $display("FAIL iread_grant%0d: got ren %b addr %h iwait %b want 1 00000040 %b",
                     k, ramREN, ramaddr, iwait, (k != 3));
         end
      end
      vectors++;
      if (iload !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL iread_data: got %h want deadbeef", iload);
      end
      next_cycle();
      ramstate = 2'd0;
      #3;
      vectors++;
      if (ramREN !== 1'b0 || iwait !== 1'b1) begin
         miscompares++;
         $display("FAIL iread_gap: got ren %b iwait %b want 0 1", ramREN, iwait);
      end
      iREN = 0;
      next_cycle();
   endtask

   task automatic test_priority();
      do_reset();
      iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
      #3;
      vectors++;
      if (ramWEN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin
         miscompares++;
         $display("FAIL prio_idle: got wen %b iwait %b dwait %b want 0 1 1", ramWEN, iwait, dwait);
      end
      next_cycle();
      ramstate = 2'd2;
      #3;
      vectors++;
      if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234 || ramaddr !== 32'h80 ||
          dwait !== 1'b0 || iwait !== 1'b1) begin
         miscompares++;
         $display("FAIL prio_dgnt: got wen %b ren %b store %h addr %h dwait %b iwait %b want 1 0 00001234 00000080 0 1",
                  ramWEN, ramREN, ramstore, ramaddr, dwait, iwait);
      end
      next_cycle();
      dWEN = 0; ramstate = 2'd0;
      #3;
      vectors++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
         miscompares++;
         $display("FAIL prio_gap: got ren %b wen %b want 0 0", ramREN, ramWEN);
      end
      next_cycle();
      ramstate = 2'd2;
      #3;
      vectors++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h44 || iwait !== 1'b0) begin
         miscompares++;
         $display("FAIL prio_ignt: got ren %b addr %h iwait %b want 1 00000044 0", ramREN, ramaddr, iwait);
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_alternation();
      int exp_d[4];
      int got_d[4];
      int ngrants = 0;
      int gc = 0;
`ifdef MEM_ARBITER_RR_EN
      exp_d = '{1, 0, 1, 0};
`else
      exp_d = '{1, 1, 1, 1};
`endif
      do_reset();
      iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h200;
      for (int c = 0; c < 40 && ngrants < 4; c++) begin
         ramstate = 2'd1;
         #2;
         if (ramREN || ramWEN) begin
            gc++;
            if (gc == 1) begin
               got_d[ngrants] = (ramaddr == 32'h200) ? 1 : 0;
               ngrants++;
            end
         end else gc = 0;
         if (gc == 2) ramstate = 2'd2;
         next_cycle();
      end
      for (int g = 0; g < 4; g++) begin
         vectors++;
         if (g >= ngrants || got_d[g] !== exp_d[g]) begin
            miscompares++;
            $display("FAIL alternate_grant%0d: got dcache=%0d want dcache=%0d (grants seen %0d)",
                     g, (g < ngrants) ? got_d[g] : -1, exp_d[g], ngrants);
         end
      end
      do_reset();
   endtask

   task automatic test_timeout();
      int early = 0;
      do_reset();
      iREN = 1; ramstate = 2'd1;
      next_cycle();
      for (int k = 1; k < TO; k++) begin
         #3;
         if (arb_err !== 1'b0 || iwait !== 1'b1 || ramREN !== 1'b1) early++;
         next_cycle();
      end
      vectors++;
      if (early != 0) begin
         miscompares++;
         $display("FAIL timeout_early: got %0d bad cycles before %0d want 0", early, TO);
      end
      #3;
      vectors++;
      if (arb_err !== 1'b1 || iwait !== 1'b0 || ramREN !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_fire: got err %b iwait %b ren %b want 1 0 1", arb_err, iwait, ramREN);
      end
      next_cycle();
      iREN = 0; ramstate = 2'd0;
      #3;
      vectors++;
      if (ramREN !== 1'b0 || arb_err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_after: got ren %b err %b want 0 1", ramREN, arb_err);
      end
      for (int k = 0; k < 5; k++) next_cycle();
      #3;
      vectors++;
      if (arb_err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_sticky: got %b want 1", arb_err);
      end
      do_reset();
      #3;
      vectors++;
      if (arb_err !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_cleared: got %b want 0", arb_err);
      end
      next_cycle();
   endtask

   task automatic test_error();
      do_reset();
      iREN = 1; iaddr = 32'h10;
      next_cycle();
      ramstate = 2'd3;
      #3;
      vectors++;
      if (arb_err !== 1'b1 || iwait !== 1'b0 || ramREN !== 1'b1) begin
         miscompares++;
         $display("FAIL error_cycle: got err %b iwait %b ren %b want 1 0 1", arb_err, iwait, ramREN);
      end
      next_cycle();
      ramstate = 2'd0;
      #3;
      vectors++;
      if (ramREN !== 1'b0 || iwait !== 1'b1 || arb_err !== 1'b1) begin
         miscompares++;
         $display("FAIL error_next: got ren %b iwait %b err %b want 0 1 1", ramREN, iwait, arb_err);
      end
      iREN = 0;
      next_cycle();
   endtask

   // Runs straight after test_error so the flag is set when RST arrives.
   task automatic test_reset_mid_grant();
      dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h55; ramstate = 2'd1;
      next_cycle();
      next_cycle();
      #3;
      vectors++;
      if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_pre: got wen %b ren %b want 1 0", ramWEN, ramREN);
      end
      RST = 1;
      #1;
      vectors++;
      if (ramWEN !== 1'b0 || ramREN !== 1'b0 || arb_err !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_mid_async: got wen %b ren %b err %b dwait %b addr %h want 0 0 0 1 00000000",
                  ramWEN, ramREN, arb_err, dwait, ramaddr);
      end
      next_cycle();
      idle_inputs();
      RST = 0;
      next_cycle();
   endtask

   task automatic test_random();
      int r;
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         iREN   = ($urandom_range(0, 3) != 0);
         dREN   = ($urandom_range(0, 2) == 0);
         dWEN   = ($urandom_range(0, 3) == 0);
         iaddr  = $urandom;
         daddr  = $urandom;
         dstore = $urandom;
         ramload = $urandom;
         r = $urandom_range(0, 63);
         ramstate = (r == 0) ? 2'd3 : (r < 30) ? 2'd1 : (r < 50) ? 2'd2 : 2'd0;
         #3;
         model_outputs();
         vectors++;
         if ({iwait, dwait, ramREN, ramWEN, arb_err} !== {e_iwait, e_dwait, e_ren, e_wen, e_err}) begin
            miscompares++;
            $display("FAIL rand_ctrl cycle %0d: got iw/dw/ren/wen/err %b want %b", c,
                     {iwait, dwait, ramREN, ramWEN, arb_err}, {e_iwait, e_dwait, e_ren, e_wen, e_err});
         end
         vectors++;
         if (ramaddr !== e_addr || ramstore !== e_store) begin
            miscompares++;
            $display("FAIL rand_bus cycle %0d: got addr %h store %h want %h %h", c,
                     ramaddr, ramstore, e_addr, e_store);
         end
         vectors++;
         if (iload !== ramload || dload !== ramload) begin
            miscompares++;
            $display("FAIL rand_load cycle %0d: got i %h d %h want %h", c, iload, dload, ramload);
         end
         model_step();
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      RST = 1;
      idle_inputs();
      test_reset();
      test_icache_read();
      test_priority();
      test_alternation();
      test_timeout();
      test_error();
      test_reset_mid_grant();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
